power_sqrt: RTL and testbench

//   Inverse of the square_sum power stage: converts a power sample |x|^2

---
 rtl/power_pkg.sv | 37 +++
 rtl/sqrt_stage.sv | 86 ++++++++
 rtl/power_sqrt.sv | 150 +++++++++++++++
 tb/tb_power_sqrt.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_pkg.sv
// -----------------------------------------------------------------------------
// power_pkg
//   Shared definitions for the power-domain blocks (square_sum, power_sqrt).
//   Holds the default sample widths, the fixed pipeline latency of the square
//   root, the per-stage record carried down the root pipeline, and a helper
//   that derives the root width from the power width.
// -----------------------------------------------------------------------------
package power_pkg;

  // Default width of an unsigned power sample |x|^2.
  localparam int IN_W_DEF  = 31;

  // Root width: the root of an N-bit value needs ceil(N/2) bits.
  localparam int OUT_W_DEF = (IN_W_DEF + 1) / 2;

  // Zero-extended radicand width and partial-remainder width of the root.
  localparam int X_W_DEF   = 2 * OUT_W_DEF;
  localparam int R_W_DEF   = OUT_W_DEF + 2;

  // Input register + one register per root digit; the output register shares
  // the final edge count (sample at edge N -> out_en after edge N+OUT_W+1).
  localparam int LATENCY   = OUT_W_DEF + 1;

  // One slot of the root pipeline at the default widths.
  typedef struct packed {
    logic                 valid;  // slot holds a live sample
    logic [X_W_DEF-1:0]   x;      // zero-extended radicand
    logic [R_W_DEF-1:0]   r;      // partial remainder
    logic [OUT_W_DEF-1:0] q;      // partial root
  } sqrt_stage_t;

  // Root width needed for a given power width.
  function automatic int half_ceil(input int w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/sqrt_stage.sv
// -----------------------------------------------------------------------------
// sqrt_stage
//   One registered iteration of the digit-by-digit (restoring) integer square
//   root. Stage K consumes radicand bit pair K, counted from the MSB pair.
//
//   Ports
//     clk      in   1         clock, posedge
//     rst      in   1         synchronous active-high reset (clears o_valid)
//     i_valid  in   1         incoming slot holds a live sample
//     i_x      in   2*OUT_W   zero-extended radicand, passed through
//     i_r      in   OUT_W+2   partial remainder from the previous stage
//     i_q      in   OUT_W     partial root from the previous stage
//     o_valid  out  1         registered valid
//     o_x      out  2*OUT_W   registered radicand
//     o_r      out  OUT_W+2   registered updated remainder
//     o_q      out  OUT_W     registered updated root
// -----------------------------------------------------------------------------
module sqrt_stage #(
  parameter int OUT_W = 16,
  parameter int K     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [2*OUT_W-1:0] i_x,
  input  logic [OUT_W+1:0]   i_r,
  input  logic [OUT_W-1:0]   i_q,
  output logic               o_valid,
  output logic [2*OUT_W-1:0] o_x,
  output logic [OUT_W+1:0]   o_r,
  output logic [OUT_W-1:0]   o_q
);

  localparam int R_W   = OUT_W + 2;
  // Bit position of the low bit of the pair this stage brings down.
  localparam int SHIFT = 2 * (OUT_W - 1 - K);

  logic [1:0]       w_pair;
  logic [R_W-1:0]   w_r_shift;
  logic [R_W-1:0]   w_t;
  logic             w_ge;
  logic [R_W-1:0]   w_r_next;
  logic [OUT_W-1:0] w_q_next;

  logic             r_valid;
  logic [2*OUT_W-1:0] r_x;
  logic [R_W-1:0]   r_r;
  logic [OUT_W-1:0] r_q;

  always_comb begin
    w_pair    = 2'(i_x >> SHIFT);
    // Bring down the next pair; the bits shifted out of r are always zero
    // because r <= 2*q never outgrows the previous stage's partial root.
    w_r_shift = (i_r << 2) | R_W'(w_pair);
    // Trial subtrahend 4q+1: appending a 1 digit adds 2*(2q)+1 to the square.
    w_t       = {i_q, 2'b01};
    w_ge      = (w_r_shift >= w_t);
    w_r_next  = w_ge ? (w_r_shift - w_t) : w_r_shift;
    w_q_next  = (i_q << 1) | OUT_W'(w_ge);
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value; blocking here would collapse the
  // pipeline into a ripple within one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
    end
  end

  // NOTE: the data registers carry no reset; the valid bit alone says whether
  // their content means anything, which keeps reset fan-out off the datapath.
  always_ff @(posedge clk) begin
    r_x <= i_x;
    r_r <= w_r_next;
    r_q <= w_q_next;
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_r     = r_r;
  assign o_q     = r_q;

endmodule

// File: rtl/power_sqrt.sv
// -----------------------------------------------------------------------------
// power_sqrt
//   Converts a power sample |x|^2 back to a linear magnitude |x| with a fully
//   pipelined digit-by-digit integer square root. One sample per clock, fixed
//   latency OUT_W+1, no backpressure. Same in_en/out_en strobe protocol as the
//   upstream square_sum stage.
//
//   Parameters
//     IN_W   power input width (unsigned)
//     OUT_W  magnitude width, ceil(IN_W/2)
//     ROUND  0 = floor(sqrt); 1 = round-to-nearest, saturated at 2^OUT_W-1
//
//   Ports
//     clk        in   1        clock, posedge
//     rst        in   1        synchronous active-high reset
//     power      in   IN_W     unsigned power sample, valid with in_en
//     in_en      in   1        input strobe, may be high every cycle
//     magnitude  out  OUT_W    root (floor or rounded per ROUND)
//     remainder  out  OUT_W+1  power - floor_root^2, range 0..2*floor_root
//     out_en     out  1        one pulse per accepted sample
// -----------------------------------------------------------------------------
module power_sqrt
  import power_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = half_ceil(IN_W),
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  power,
  input  logic             in_en,
  output logic [OUT_W-1:0] magnitude,
  output logic [OUT_W:0]   remainder,
  output logic             out_en
);

  localparam int X_W = 2 * OUT_W;
  localparam int R_W = OUT_W + 2;

  // Input register.
  logic             r_in_valid;
  logic [X_W-1:0]   r_in_x;

  // Outputs of each root stage; index k is the register after stage k.
  logic             w_valid [0:OUT_W-1];
  logic [X_W-1:0]   w_x     [0:OUT_W-1];
  logic [R_W-1:0]   w_r     [0:OUT_W-1];
  logic [OUT_W-1:0] w_q     [0:OUT_W-1];

  // Output-stage combinational terms.
  logic [OUT_W-1:0] w_q_fin;
  logic [OUT_W:0]   w_rem_fin;
  logic             w_round_up;
  logic [OUT_W-1:0] w_mag_next;

  // Output register.
  logic             r_out_en;
  logic [OUT_W-1:0] r_magnitude;
  logic [OUT_W:0]   r_remainder;

  // ---------------------------------------------------------------------------
  // Input register. in_en is ignored while rst is high because the reset
  // branch wins. An odd IN_W picks up its leading zero from the cast.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_valid <= 1'b0;
    end else begin
      r_in_valid <= in_en;
    end
  end

  always_ff @(posedge clk) begin
    r_in_x <= X_W'(power);
  end

  // ---------------------------------------------------------------------------
  // Root chain: stage 0 starts from r = 0, q = 0 and handles the MSB pair.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < OUT_W; k++) begin : g_stage
    if (k == 0) begin : g_first
      sqrt_stage #(
        .OUT_W (OUT_W),
        .K     (k)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_in_valid),
        .i_x     (r_in_x),
        .i_r     ({R_W{1'b0}}),
        .i_q     ({OUT_W{1'b0}}),
        .o_valid (w_valid[k]),
        .o_x     (w_x[k]),
        .o_r     (w_r[k]),
        .o_q     (w_q[k])
      );
    end else begin : g_next
      sqrt_stage #(
        .OUT_W (OUT_W),
        .K     (k)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_valid[k-1]),
        .i_x     (w_x[k-1]),
        .i_r     (w_r[k-1]),
        .i_q     (w_q[k-1]),
        .o_valid (w_valid[k]),
        .o_x     (w_x[k]),
        .o_r     (w_r[k]),
        .o_q     (w_q[k])
      );
    end
  end

  // ---------------------------------------------------------------------------
  // Rounding. sqrt(p) >= q + 1/2 exactly when p - q^2 > q for integers, so the
  // floor remainder alone decides the round-up. The all-ones root cannot grow.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_q_fin    = w_q[OUT_W-1];
    // The final remainder is at most 2*q, so its top bit is always zero.
    w_rem_fin  = (OUT_W+1)'(w_r[OUT_W-1]);
    w_round_up = (ROUND != 0) && (w_rem_fin > {1'b0, w_q_fin}) && !(&w_q_fin);
    w_mag_next = w_q_fin + OUT_W'(w_round_up);
  end

  // ---------------------------------------------------------------------------
  // Output register. Data holds its last value through bubbles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_en    <= 1'b0;
      r_magnitude <= '0;
      r_remainder <= '0;
    end else begin
      r_out_en <= w_valid[OUT_W-1];
      if (w_valid[OUT_W-1]) begin
        r_magnitude <= w_mag_next;
        r_remainder <= w_rem_fin;
      end
    end
  end

  assign out_en    = r_out_en;
  assign magnitude = r_magnitude;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_power_sqrt.sv
// -----------------------------------------------------------------------------
// tb_power_sqrt
//   Drives a floor instance and a rounding instance of power_sqrt from the same
//   stimulus and compares both against an arithmetic square-root model.
// -----------------------------------------------------------------------------
module tb_power_sqrt;

  localparam int IN_W  = 31;
  localparam int OUT_W = 16;
  localparam int LAT   = OUT_W + 1;

  typedef struct {
    int unsigned       edge_n;
    longint unsigned   q;
    longint unsigned   rnd;
    longint unsigned   rem;
  } exp_t;

  typedef struct {
    int unsigned       edge_n;
    logic              en0;
    logic              en1;
    logic [OUT_W-1:0]  m0;
    logic [OUT_W-1:0]  m1;
    logic [OUT_W:0]    r0;
    logic [OUT_W:0]    r1;
  } got_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_en;
  logic [IN_W-1:0]  pwr;

  logic [OUT_W-1:0] mag0, mag1;
  logic [OUT_W:0]   rem0, rem1;
  logic             oen0, oen1;

  int unsigned edge_no = 0;
  int          n_pass  = 0;
  int          n_total = 0;

  exp_t exp_q[$];
  got_t got_q[$];

  always #5 clk = ~clk;

  power_sqrt #(.IN_W(IN_W), .OUT_W(OUT_W), .ROUND(0)) dut_floor (
    .clk       (clk),
    .rst       (rst),
    .power     (pwr),
    .in_en     (in_en),
    .magnitude (mag0),
    .remainder (rem0),
    .out_en    (oen0)
  );

  power_sqrt #(.IN_W(IN_W), .OUT_W(OUT_W), .ROUND(1)) dut_round (
    .clk       (clk),
    .rst       (rst),
    .power     (pwr),
    .in_en     (in_en),
    .magnitude (mag1),
    .remainder (rem1),
    .out_en    (oen1)
  );

  // ---------------------------------------------------------------------------
  // Reference model: largest q with q*q <= p, found by binary search.
  // ---------------------------------------------------------------------------
  function automatic longint unsigned ref_isqrt(input longint unsigned p);
    longint unsigned lo = 0;
    longint unsigned hi = 65536;
    longint unsigned mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= p) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Nearest integer to sqrt(p): round up when (q + 1/2)^2 < p, i.e. 4p > (2q+1)^2.
  function automatic longint unsigned ref_round(input longint unsigned p);
    longint unsigned q = ref_isqrt(p);
    if ((4 * p > (2 * q + 1) * (2 * q + 1)) && (q < 65535)) return q + 1;
    return q;
  endfunction

  // ---------------------------------------------------------------------------
  // One clock of stimulus. Accepted samples are queued with the edge at which
  // they must appear; a reset edge discards every sample not yet delivered.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic r, input logic en, input logic [IN_W-1:0] p);
    exp_t e;
    rst   = r;
    in_en = en;
    pwr   = p;
    @(posedge clk);
    edge_no++;
    if (r) begin
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].edge_n >= edge_no) exp_q.delete(i);
    end else if (en) begin
      e.edge_n = edge_no + LAT;
      e.q      = ref_isqrt(longint'(p));
      e.rnd    = ref_round(longint'(p));
      e.rem    = longint'(p) - e.q * e.q;
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  // Capture every output pulse, away from the active edge.
  always @(negedge clk) begin
    got_t g;
    if (oen0 === 1'b1 || oen1 === 1'b1) begin
      g.edge_n = edge_no;
      g.en0    = oen0;
      g.en1    = oen1;
      g.m0     = mag0;
      g.m1     = mag1;
      g.r0     = rem0;
      g.r1     = rem1;
      got_q.push_back(g);
    end
  end

  // Pair delivered outputs with accepted samples in order, then empty both.
  task automatic scoreboard(input string name);
    int n;
    n_total++;
    if (got_q.size() == exp_q.size()) n_pass++;
    else $display("FAIL %s count: out_en pulses=%0d accepted=%0d", name, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (got_q[i].edge_n !== exp_q[i].edge_n || got_q[i].en0 !== 1'b1 || got_q[i].en1 !== 1'b1)
        $display("FAIL %s timing[%0d]: edge=%0d en0=%b en1=%b expected edge=%0d both 1",
                 name, i, got_q[i].edge_n, got_q[i].en0, got_q[i].en1, exp_q[i].edge_n);
      else n_pass++;
      n_total++;
      if (got_q[i].m0 !== OUT_W'(exp_q[i].q))
        $display("FAIL %s floor_mag[%0d]: got %0d expected %0d", name, i, got_q[i].m0, exp_q[i].q);
      else n_pass++;
      n_total++;
      if (got_q[i].m1 !== OUT_W'(exp_q[i].rnd))
        $display("FAIL %s round_mag[%0d]: got %0d expected %0d", name, i, got_q[i].m1, exp_q[i].rnd);
      else n_pass++;
      n_total++;
      if (got_q[i].r0 !== (OUT_W+1)'(exp_q[i].rem) || got_q[i].r1 !== (OUT_W+1)'(exp_q[i].rem))
        $display("FAIL %s remainder[%0d]: got %0d/%0d expected %0d", name, i,
                 got_q[i].r0, got_q[i].r1, exp_q[i].rem);
      else n_pass++;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 3 + LAT; i++) begin
      if (i < 3) cycle(1'b1, 1'b1, IN_W'($urandom));
      else       cycle(1'b0, 1'b0, '0);
      n_total++;
      if (oen0 !== 1'b0 || oen1 !== 1'b0 || mag0 !== '0 || mag1 !== '0 || rem0 !== '0 || rem1 !== '0)
        $display("FAIL reset_state cycle %0d: en=%b/%b mag=%0d/%0d rem=%0d/%0d expected all 0",
                 i, oen0, oen1, mag0, mag1, rem0, rem1);
      else n_pass++;
    end
    scoreboard("reset");
  endtask

  task automatic test_exact_square();
    cycle(1'b0, 1'b1, 31'd25);
    idle(LAT + 3);
    n_total++;
    if (got_q.size() != 1 || got_q[0].m0 !== 16'd5 || got_q[0].m1 !== 16'd5 || got_q[0].r0 !== 17'd0)
      $display("FAIL exact25: pulses=%0d mag=%0d/%0d rem=%0d expected 1 pulse 5/5 rem 0",
               got_q.size(), (got_q.size() > 0) ? got_q[0].m0 : 16'd0,
               (got_q.size() > 0) ? got_q[0].m1 : 16'd0, (got_q.size() > 0) ? got_q[0].r0 : 17'd0);
    else n_pass++;
    scoreboard("exact_square");
  endtask

  task automatic test_non_square();
    cycle(1'b0, 1'b1, 31'd24);
    idle(LAT + 3);
    n_total++;
    if (got_q.size() != 1 || got_q[0].m0 !== 16'd4 || got_q[0].m1 !== 16'd5 || got_q[0].r0 !== 17'd8)
      $display("FAIL non_square24: pulses=%0d expected mag floor 4 round 5 rem 8", got_q.size());
    else n_pass++;
    scoreboard("non_square");
  endtask

  task automatic test_extremes();
    cycle(1'b0, 1'b1, 31'd0);
    cycle(1'b0, 1'b1, 31'h7FFF_FFFF);
    idle(LAT + 3);
    n_total++;
    if (got_q.size() != 2 || got_q[0].m0 !== 16'd0 || got_q[0].m1 !== 16'd0 || got_q[0].r0 !== 17'd0)
      $display("FAIL extreme_zero: pulses=%0d expected mag 0 rem 0", got_q.size());
    else n_pass++;
    n_total++;
    if (got_q.size() != 2 || got_q[1].m0 !== 16'd46340 || got_q[1].m1 !== 16'd46341 ||
        got_q[1].r0 !== 17'd88047)
      $display("FAIL extreme_max: pulses=%0d expected floor 46340 round 46341 rem 88047", got_q.size());
    else n_pass++;
    scoreboard("extremes");
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, IN_W'(k * k + k));
    idle(3);
    for (int k = 20; k < 22; k++) cycle(1'b0, 1'b1, IN_W'(k * k + k));
    idle(LAT + 3);
    n_total++;
    if (got_q.size() != 22) begin
      $display("FAIL stream_count: pulses=%0d expected 22", got_q.size());
    end else begin
      n_pass++;
      for (int k = 0; k < 22; k++) begin
        n_total++;
        if (got_q[k].m0 !== OUT_W'(k) || got_q[k].r0 !== (OUT_W+1)'(k) || got_q[k].m1 !== OUT_W'(k))
          $display("FAIL stream_value[%0d]: mag=%0d/%0d rem=%0d expected %0d", k,
                   got_q[k].m0, got_q[k].m1, got_q[k].r0, k);
        else n_pass++;
      end
      n_total++;
      if (got_q[19].edge_n - got_q[0].edge_n != 19 || got_q[20].edge_n - got_q[19].edge_n != 4)
        $display("FAIL stream_spacing: burst span=%0d gap step=%0d expected 19 and 4",
                 got_q[19].edge_n - got_q[0].edge_n, got_q[20].edge_n - got_q[19].edge_n);
      else n_pass++;
    end
    scoreboard("streaming");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) cycle((i == 6) ? 1'b1 : 1'b0, 1'b1, IN_W'($urandom));
    idle(LAT + 3);
    n_total++;
    if (got_q.size() != 3)
      $display("FAIL reset_mid_count: pulses=%0d expected 3", got_q.size());
    else n_pass++;
    scoreboard("reset_mid");
  endtask

  task automatic test_random();
    longint unsigned k, p;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: p = longint'(IN_W'($urandom));
        1: p = $urandom_range(0, 1000);
        2: begin
          k = $urandom_range(1, 46340);
          case ($urandom_range(0, 4))
            0: p = k * k - 1;
            1: p = k * k;
            2: p = k * k + 1;
            3: p = k * k + k;
            default: p = k * k + k + 1;
          endcase
        end
        default: p = 64'h7FFF_FFFF - $urandom_range(0, 100000);
      endcase
      cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0, IN_W'(p));
    end
    idle(LAT + 3);
    scoreboard("random");
  endtask

  initial begin
    rst   = 1'b1;
    in_en = 1'b0;
    pwr   = '0;
    test_reset();
    test_exact_square();
    test_non_square();
    test_extremes();
    test_streaming();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
